// File: rtl/hex_rate_counter.sv
// Multi-digit hex/decimal up/down counter with a built-in rate divider.
// Digits feeds one hex_decoder per nibble; Tick marks each visible count step.
module hex_rate_counter #(
  parameter int DIGITS  = 2,
  parameter int DIVISOR = 50_000_000
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Enable,
  input  logic [1:0]            Speed,
  input  logic                  Mode,
  input  logic                  UpDown,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  output logic [4*DIGITS-1:0]   Digits,
  output logic                  Tick,
  output logic                  Wrap
);

  localparam int DW   = 4 * DIGITS;
  localparam int RC_W = (4 * DIVISOR > 1) ? $clog2(4 * DIVISOR) : 1;

  logic [RC_W-1:0] rate_count_q, rate_count_d;
  logic [RC_W-1:0] period_m1;
  logic [DW-1:0]   digits_q, digits_d;
  logic [DW-1:0]   step_value, load_value;
  logic            wrap_q, wrap_d;
  logic            carry_out;

  // Reload value for the divider; sampled only at reload, so Speed never cuts a period short.
  always_comb begin
    period_m1 = '0;
    unique case (Speed)
      2'b00: period_m1 = '0;
      2'b01: period_m1 = RC_W'(DIVISOR - 1);
      2'b10: period_m1 = RC_W'(2 * DIVISOR - 1);
      2'b11: period_m1 = RC_W'(4 * DIVISOR - 1);
      default: period_m1 = '0;
    endcase
  end

  assign Tick = Resetn & Enable & (rate_count_q == '0);

  // Ripple carry/borrow through the digits; a digit only changes while the chain is live.
  always_comb begin
    logic       carry;
    logic [3:0] cur;
    logic [3:0] max_d;
    // NOTE: every variable gets a default before any branch, otherwise
    // paths that skip an assignment infer latches.
    step_value = digits_q;
    carry      = 1'b1;
    cur        = '0;
    max_d      = Mode ? 4'd9 : 4'hF;
    for (int k = 0; k < DIGITS; k++) begin
      cur = digits_q[4*k +: 4];
      if (carry) begin
        if (UpDown) begin
          // Covers both the normal max and decimal digits left over above 9 from hex mode.
          if (cur >= max_d) begin
            step_value[4*k +: 4] = 4'd0;
            carry                = 1'b1;
          end else begin
            step_value[4*k +: 4] = cur + 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (Mode && (cur > 4'd9)) begin
            step_value[4*k +: 4] = 4'd9;
            carry                = 1'b0;
          end else if (cur == 4'd0) begin
            step_value[4*k +: 4] = max_d;
            carry                = 1'b1;
          end else begin
            step_value[4*k +: 4] = cur - 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
    carry_out = carry;
  end

  always_comb begin
    load_value = LoadValue;
    for (int k = 0; k < DIGITS; k++) begin
      if (Mode && (LoadValue[4*k +: 4] > 4'd9)) begin
        load_value[4*k +: 4] = 4'd9;
      end
    end
  end

  // Load wins over a coincident tick and swallows it.
  always_comb begin
    rate_count_d = rate_count_q;
    digits_d     = digits_q;
    wrap_d       = 1'b0;
    if (Load) begin
      digits_d     = load_value;
      rate_count_d = period_m1;
    end else if (Tick) begin
      digits_d     = step_value;
      wrap_d       = carry_out;
      rate_count_d = period_m1;
    end else if (Enable && (rate_count_q != '0)) begin
      rate_count_d = rate_count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rate_count_q <= '0;
      digits_q     <= '0;
      wrap_q       <= 1'b0;
    end else begin
      rate_count_q <= rate_count_d;
      digits_q     <= digits_d;
      wrap_q       <= wrap_d;
    end
  end

  assign Digits = digits_q;
  assign Wrap   = wrap_q;

endmodule

// File: tb/tb_hex_rate_counter.sv
// Directed bench for hex_rate_counter (DIGITS=2, DIVISOR=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_hex_rate_counter;

  logic       Clock;
  logic       Resetn;
  logic       Enable;
  logic [1:0] Speed;
  logic       Mode;
  logic       UpDown;
  logic       Load;
  logic [7:0] LoadValue;
  logic [7:0] Digits;
  logic       Tick;
  logic       Wrap;

  int n_checks = 0;
  int n_fail   = 0;

  hex_rate_counter #(.DIGITS(2), .DIVISOR(4)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Enable    (Enable),
    .Speed     (Speed),
    .Mode      (Mode),
    .UpDown    (UpDown),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Digits    (Digits),
    .Tick      (Tick),
    .Wrap      (Wrap)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Loads v and returns at the falling edge just after the load edge.
  task automatic do_load(input logic [7:0] v, input logic mode, input logic updown,
                         input logic [1:0] speed);
    @(negedge Clock);
    Load = 1'b1; LoadValue = v; Mode = mode; UpDown = updown; Speed = speed; Enable = 1'b1;
    @(negedge Clock);
    Load = 1'b0;
  endtask

  task automatic test_reset;
    Resetn = 1'b0; Enable = 1'b1; Speed = 2'b00; Mode = 1'b0; UpDown = 1'b1;
    Load = 1'b0; LoadValue = 8'h00;
    #12;
    n_checks++; if (Digits !== 8'h00) begin n_fail++; $display("FAIL reset_digits: got %h expected 00", Digits); end
    n_checks++; if (Wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", Wrap); end
    n_checks++; if (Tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", Tick); end
  endtask

  task automatic test_hex_count_up;
    logic [7:0] exp_d;
    @(negedge Clock);
    Resetn = 1'b1;
    #1;
    n_checks++; if (Tick !== 1'b1) begin n_fail++; $display("FAIL hex_first_tick: got %b expected 1", Tick); end
    for (int i = 1; i <= 257; i++) begin
      @(negedge Clock);
      exp_d = 8'(i);
      n_checks++; if (Digits !== exp_d) begin n_fail++; $display("FAIL hex_up[%0d]: got %h expected %h", i, Digits, exp_d); end
      n_checks++; if (Wrap !== (i == 256)) begin n_fail++; $display("FAIL hex_up_wrap[%0d]: got %b expected %b", i, Wrap, (i == 256)); end
    end
  endtask

  task automatic test_decimal_rate;
    logic [7:0] exp_d;
    do_load(8'h08, 1'b1, 1'b1, 2'b01);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge Clock);
      exp_d = (c < 4) ? 8'h08 : (c < 8) ? 8'h09 : 8'h10;
      n_checks++; if (Digits !== exp_d) begin n_fail++; $display("FAIL dec_rate_digits[%0d]: got %h expected %h", c, Digits, exp_d); end
      n_checks++; if (Tick !== ((c % 4) == 3)) begin n_fail++; $display("FAIL dec_rate_tick[%0d]: got %b expected %b", c, Tick, ((c % 4) == 3)); end
    end
    do_load(8'h99, 1'b1, 1'b1, 2'b01);
    repeat (3) @(negedge Clock);
    n_checks++; if (Tick !== 1'b1) begin n_fail++; $display("FAIL dec99_tick: got %b expected 1", Tick); end
    @(negedge Clock);
    n_checks++; if (Digits !== 8'h00) begin n_fail++; $display("FAIL dec99_digits: got %h expected 00", Digits); end
    n_checks++; if (Wrap !== 1'b1) begin n_fail++; $display("FAIL dec99_wrap: got %b expected 1", Wrap); end
    @(negedge Clock);
    n_checks++; if (Wrap !== 1'b0) begin n_fail++; $display("FAIL dec99_wrap_clear: got %b expected 0", Wrap); end
    n_checks++; if (Tick !== 1'b0) begin n_fail++; $display("FAIL dec99_tick_after: got %b expected 0", Tick); end
  endtask

  task automatic test_decimal_down;
    logic [7:0] exp_d;
    do_load(8'h3C, 1'b1, 1'b0, 2'b00);
    n_checks++; if (Digits !== 8'h39) begin n_fail++; $display("FAIL dec_load_clamp: got %h expected 39", Digits); end
    for (int i = 1; i <= 9; i++) begin
      @(negedge Clock);
      exp_d = {4'h3, 4'(9 - i)};
      n_checks++; if (Digits !== exp_d) begin n_fail++; $display("FAIL dec_down[%0d]: got %h expected %h", i, Digits, exp_d); end
    end
    @(negedge Clock);
    n_checks++; if (Digits !== 8'h29) begin n_fail++; $display("FAIL dec_down_borrow: got %h expected 29", Digits); end
    n_checks++; if (Wrap !== 1'b0) begin n_fail++; $display("FAIL dec_down_wrap: got %b expected 0", Wrap); end
  endtask

  task automatic test_hex_down_wrap;
    do_load(8'h00, 1'b0, 1'b0, 2'b00);
    n_checks++; if (Digits !== 8'h00) begin n_fail++; $display("FAIL hexdn_load: got %h expected 00", Digits); end
    @(negedge Clock);
    n_checks++; if (Digits !== 8'hFF) begin n_fail++; $display("FAIL hexdn_ff: got %h expected FF", Digits); end
    n_checks++; if (Wrap !== 1'b1) begin n_fail++; $display("FAIL hexdn_wrap: got %b expected 1", Wrap); end
    @(negedge Clock);
    n_checks++; if (Digits !== 8'hFE) begin n_fail++; $display("FAIL hexdn_fe: got %h expected FE", Digits); end
    n_checks++; if (Wrap !== 1'b0) begin n_fail++; $display("FAIL hexdn_wrap_clear: got %b expected 0", Wrap); end
  endtask

  task automatic test_decimal_leftover;
    // Hex-loaded B seen in decimal mode: down gives 9 with no borrow.
    do_load(8'h1B, 1'b0, 1'b1, 2'b01);
    Mode = 1'b1; UpDown = 1'b0;
    repeat (4) @(negedge Clock);
    n_checks++; if (Digits !== 8'h19) begin n_fail++; $display("FAIL leftover_down: got %h expected 19", Digits); end
    // Up from C in decimal gives 0 and carries.
    do_load(8'h2C, 1'b0, 1'b1, 2'b00);
    Mode = 1'b1;
    @(negedge Clock);
    n_checks++; if (Digits !== 8'h30) begin n_fail++; $display("FAIL leftover_up: got %h expected 30", Digits); end
  endtask

  task automatic test_enable_hold;
    do_load(8'h20, 1'b0, 1'b1, 2'b01);
    repeat (2) @(negedge Clock);
    Enable = 1'b0;
    #1;
    n_checks++; if (Tick !== 1'b0) begin n_fail++; $display("FAIL hold_tick_drop: got %b expected 0", Tick); end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      n_checks++; if (Digits !== 8'h20) begin n_fail++; $display("FAIL hold_digits[%0d]: got %h expected 20", i, Digits); end
      n_checks++; if (Tick !== 1'b0) begin n_fail++; $display("FAIL hold_tick[%0d]: got %b expected 0", i, Tick); end
    end
    Enable = 1'b1;
    #1;
    n_checks++; if (Tick !== 1'b0) begin n_fail++; $display("FAIL reenable_tick0: got %b expected 0", Tick); end
    @(negedge Clock);
    n_checks++; if (Tick !== 1'b1) begin n_fail++; $display("FAIL reenable_tick1: got %b expected 1", Tick); end
    n_checks++; if (Digits !== 8'h20) begin n_fail++; $display("FAIL reenable_digits: got %h expected 20", Digits); end
    Load = 1'b1; LoadValue = 8'hA7;
    @(negedge Clock);
    Load = 1'b0;
    n_checks++; if (Digits !== 8'hA7) begin n_fail++; $display("FAIL load_vs_tick: got %h expected A7", Digits); end
    n_checks++; if (Tick !== 1'b0) begin n_fail++; $display("FAIL load_reload_tick: got %b expected 0", Tick); end
    Enable = 1'b0; Load = 1'b1; LoadValue = 8'h5C;
    @(negedge Clock);
    Load = 1'b0;
    n_checks++; if (Digits !== 8'h5C) begin n_fail++; $display("FAIL load_disabled: got %h expected 5C", Digits); end
    Enable = 1'b1;
  endtask

  task automatic test_async_reset;
    do_load(8'h5A, 1'b0, 1'b1, 2'b01);
    #2;
    Resetn = 1'b0;
    #1;
    n_checks++; if (Digits !== 8'h00) begin n_fail++; $display("FAIL async_digits: got %h expected 00", Digits); end
    n_checks++; if (Tick !== 1'b0) begin n_fail++; $display("FAIL async_tick: got %b expected 0", Tick); end
    @(negedge Clock);
    n_checks++; if (Digits !== 8'h00) begin n_fail++; $display("FAIL async_hold: got %h expected 00", Digits); end
    Resetn = 1'b1;
    #1;
    n_checks++; if (Tick !== 1'b1) begin n_fail++; $display("FAIL release_tick: got %b expected 1", Tick); end
    @(negedge Clock);
    n_checks++; if (Digits !== 8'h01) begin n_fail++; $display("FAIL release_step: got %h expected 01", Digits); end
    n_checks++; if (Tick !== 1'b0) begin n_fail++; $display("FAIL release_tick_after: got %b expected 0", Tick); end
  endtask

  initial begin
    test_reset();
    test_hex_count_up();
    test_decimal_rate();
    test_decimal_down();
    test_hex_down_wrap();
    test_decimal_leftover();
    test_enable_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
